// File: rtl/nexys4ddr_keypad.sv
// nexys4ddr_keypad: scanned 4x4 Pmod KYPD reader with frame debounce and key-press events
module nexys4ddr_keypad #(
  parameter int unsigned FREQ = 100_000_000,
  parameter int unsigned SCAN_RATE = 1000,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  COL,
  input  logic [3:0]  ROW,
  output logic [15:0] keys,
  output logic        any_pressed,
  output logic        key_valid,
  output logic [3:0]  key_code
);
  localparam int unsigned DIV = FREQ / (SCAN_RATE * 4);
  localparam int W = $clog2(DIV);
  logic [W-1:0] tcnt;
  logic [3:0]   row_m, row_s, cnt, code;
  logic [1:0]   col_idx;
  logic [15:0]  raw, frame, prev, pending, emit, new_p;
  logic         tick, done, commit;
  function automatic logic [3:0] lbl(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'd0: lbl = 4'h1;  4'd1: lbl = 4'h2;  4'd2: lbl = 4'h3;  4'd3: lbl = 4'hA;
      4'd4: lbl = 4'h4;  4'd5: lbl = 4'h5;  4'd6: lbl = 4'h6;  4'd7: lbl = 4'hB;
      4'd8: lbl = 4'h7;  4'd9: lbl = 4'h8;  4'd10: lbl = 4'h9; 4'd11: lbl = 4'hC;
      4'd12: lbl = 4'h0; 4'd13: lbl = 4'hF; 4'd14: lbl = 4'hE; default: lbl = 4'hD;
    endcase
  endfunction
  assign COL = ~(4'b0001 << col_idx);
  always_comb begin
    tick = tcnt == '0;
    done = tick && col_idx == 2'd3;
    frame = raw;
    for (int r = 0; r < 4; r++)
      if (tick) frame[lbl(2'(r), col_idx)] = ~row_s[r];
    commit = done && frame == prev && cnt < 4'(DEBOUNCE) && cnt + 4'd1 == 4'(DEBOUNCE);
    new_p = commit ? frame & ~keys : '0;
    emit = pending & (~pending + 16'd1);
    code = '0;
    for (int i = 15; i >= 0; i--)
      if (pending[i]) code = 4'(i);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= W'(DIV - 1);
      row_m <= 4'hF;
      row_s <= 4'hF;
      col_idx <= '0;
      raw <= '0;
      prev <= '0;
      cnt <= '0;
      keys <= '0;
      any_pressed <= 1'b0;
      pending <= '0;
      key_valid <= 1'b0;
      key_code <= '0;
    end else begin
      row_m <= ROW;
      row_s <= row_m;
      tcnt <= tick ? W'(DIV - 1) : tcnt - 1'b1;
      if (tick) begin
        raw <= frame;
        col_idx <= col_idx + 2'd1;
      end
      if (done) begin
        if (frame != prev) begin
          prev <= frame;
          cnt <= '0;
        end else if (cnt < 4'(DEBOUNCE)) cnt <= cnt + 4'd1;
      end
      if (commit) begin
        keys <= frame;
        any_pressed <= |frame;
      end
      pending <= (pending & ~emit) | new_p;
      key_valid <= |pending;
      if (|pending) key_code <= code;
    end
  end
endmodule
